// File: rtl/calc_pkg.sv
// Shared encodings for the calculator keypad controller: key codes, ALU ops,
// FSM states and display selects.
package calc_pkg;

  localparam logic [3:0] KEY_9   = 4'h9;
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_EQ  = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam logic [1:0] DISP_A   = 2'b00;
  localparam logic [1:0] DISP_B   = 2'b01;
  localparam logic [1:0] DISP_RES = 2'b10;
  localparam logic [1:0] DISP_ERR = 2'b11;

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_EXEC    = 3'd2,
    S_WAIT    = 3'd3,
    S_SHOW    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  // Operator keys A/B/C map onto consecutive ALU op codes.
  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    logic [3:0] t;
    t = k - KEY_ADD;
    return t[1:0];
  endfunction

  function automatic int unsigned shift_in(input int unsigned acc, input logic [3:0] d);
    return acc * 32'd10 + 32'(d);
  endfunction

endpackage

// File: rtl/calc_digit_lim.sv
// Per-operand digit counter: counts accepted digits and saturates at MAX_DIGITS.
// clr together with inc loads a count of one (first digit of a fresh operand).
module calc_digit_lim #(
  parameter int MAX_DIGITS = 4,
  parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          full
);

  assign full = (count == CW'(MAX_DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          count <= '0;
    else if (clr)        count <= inc ? CW'(1) : '0;
    else if (inc && !full) count <= count + CW'(1);
  end

endmodule

// File: rtl/calc_ctrl.sv
// Keypad sequencing FSM: builds A, operator and B from key strobes, runs the
// external ALU through a start/done handshake and selects what the display shows.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int DW         = 14,
  parameter int RW         = 28,
  parameter int TO_CYC     = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  output logic          alu_start,
  output logic [1:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic          alu_done,
  input  logic [RW-1:0] alu_result,
  input  logic          alu_err,
  output logic [RW-1:0] disp_val,
  output logic [1:0]    disp_sel,
  output logic          err,
  output logic          busy
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(TO_CYC + 1);

  state_t        state, state_n;
  logic [DW-1:0] a, a_n, b, b_n;
  logic [RW-1:0] result, result_n;
  logic [1:0]    op, op_n;
  logic          clr_pend, clr_pend_n;
  logic [TW-1:0] to_cnt, to_cnt_n;

  logic          clr_a, inc_a, clr_b, inc_b, full_a, full_b, clr_all;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          is_digit, is_op, is_eq, is_clr;

  assign is_digit = key_valid && (key_code <= KEY_9);
  assign is_op    = key_valid && (key_code inside {KEY_ADD, KEY_SUB, KEY_MUL});
  assign is_eq    = key_valid && (key_code == KEY_EQ);
  assign is_clr   = key_valid && (key_code == KEY_CLR);

  calc_digit_lim #(.MAX_DIGITS(MAX_DIGITS), .CW(CW)) u_lim_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .inc(inc_a), .count(cnt_a), .full(full_a)
  );

  calc_digit_lim #(.MAX_DIGITS(MAX_DIGITS), .CW(CW)) u_lim_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .inc(inc_b), .count(cnt_b), .full(full_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_ENTER_A;
      a        <= '0;
      b        <= '0;
      result   <= '0;
      op       <= OP_ADD;
      clr_pend <= 1'b0;
      to_cnt   <= '0;
    end else begin
      state    <= state_n;
      a        <= a_n;
      b        <= b_n;
      result   <= result_n;
      op       <= op_n;
      clr_pend <= clr_pend_n;
      to_cnt   <= to_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    a_n        = a;
    b_n        = b;
    result_n   = result;
    op_n       = op;
    clr_pend_n = clr_pend;
    to_cnt_n   = to_cnt;
    clr_a      = 1'b0;
    inc_a      = 1'b0;
    clr_b      = 1'b0;
    inc_b      = 1'b0;
    clr_all    = 1'b0;

    case (state)
      S_ENTER_A: begin
        if (is_clr) clr_all = 1'b1;
        else if (is_digit && !full_a) begin
          a_n   = DW'(shift_in(32'(a), key_code));
          inc_a = 1'b1;
        end else if (is_op && cnt_a != '0) begin
          op_n    = key_to_op(key_code);
          b_n     = '0;
          clr_b   = 1'b1;
          state_n = S_ENTER_B;
        end
      end
      S_ENTER_B: begin
        if (is_clr) clr_all = 1'b1;
        else if (is_digit && !full_b) begin
          b_n   = DW'(shift_in(32'(b), key_code));
          inc_b = 1'b1;
        end else if (is_op && cnt_b == '0) begin
          op_n = key_to_op(key_code);
        end else if (is_eq && cnt_b != '0) begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_clr) clr_all = 1'b1;
        else begin
          state_n    = S_WAIT;
          to_cnt_n   = '0;
          clr_pend_n = 1'b0;
        end
      end
      S_WAIT: begin
        // A clear arriving with done/timeout counts as already pending.
        if (alu_done || to_cnt == TW'(TO_CYC - 1)) begin
          to_cnt_n   = '0;
          clr_pend_n = 1'b0;
          if (clr_pend || is_clr) clr_all = 1'b1;
          else if (alu_done) begin
            result_n = alu_result;
            state_n  = alu_err ? S_ERR : S_SHOW;
          end else begin
            state_n = S_ERR;
          end
        end else begin
          to_cnt_n = to_cnt + TW'(1);
          if (is_clr) clr_pend_n = 1'b1;
        end
      end
      S_SHOW, S_ERR: begin
        if (is_clr) clr_all = 1'b1;
        else if (is_digit) begin
          a_n     = DW'(key_code);
          b_n     = '0;
          clr_a   = 1'b1;
          inc_a   = 1'b1;
          clr_b   = 1'b1;
          state_n = S_ENTER_A;
        end
      end
      default: clr_all = 1'b1;
    endcase

    if (clr_all) begin
      state_n    = S_ENTER_A;
      a_n        = '0;
      b_n        = '0;
      result_n   = '0;
      op_n       = OP_ADD;
      clr_pend_n = 1'b0;
      to_cnt_n   = '0;
      clr_a      = 1'b1;
      clr_b      = 1'b1;
      inc_a      = 1'b0;
      inc_b      = 1'b0;
    end
  end

  assign alu_op = op;
  assign alu_a  = a;
  assign alu_b  = b;

  always_comb begin
    alu_start = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    disp_val  = '0;
    disp_sel  = DISP_A;
    case (state)
      S_ENTER_A: begin disp_val = RW'(a); disp_sel = DISP_A; end
      S_ENTER_B: begin disp_val = RW'(b); disp_sel = DISP_B; end
      S_EXEC:    begin disp_val = RW'(b); disp_sel = DISP_B; alu_start = 1'b1; busy = 1'b1; end
      S_WAIT:    begin disp_val = RW'(b); disp_sel = DISP_B; busy = 1'b1; end
      S_SHOW:    begin disp_val = result; disp_sel = DISP_RES; end
      S_ERR:     begin disp_sel = DISP_ERR; err = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: directed scenarios plus random key streams,
// with the bench acting as the ALU and a calculator-level model giving expectations.
module tb_calc_ctrl;

  localparam int MAX_DIGITS = 4;
  localparam int DW         = 14;
  localparam int RW         = 28;
  localparam int TO_CYC     = 255;

  localparam int PA = 0, PB = 1, PX = 2, PS = 3, PE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_code = 4'h0;
  logic          alu_start;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b;
  logic          alu_done = 1'b0;
  logic [RW-1:0] alu_result = '0;
  logic          alu_err = 1'b0;
  logic [RW-1:0] disp_val;
  logic [1:0]    disp_sel;
  logic          err, busy;

  int n_checks = 0, n_errors = 0;
  int n_starts = 0, exp_starts = 0;
  int m_phase, m_a, m_na, m_b, m_nb, m_op, m_res;

  calc_ctrl #(.MAX_DIGITS(MAX_DIGITS), .DW(DW), .RW(RW), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .disp_val(disp_val), .disp_sel(disp_sel), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (alu_start) n_starts++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_phase = PA; m_a = 0; m_na = 0; m_b = 0; m_nb = 0; m_op = 0; m_res = 0;
  endtask

  task automatic model_key(input int k);
    if (k == 14) model_reset();
    else case (m_phase)
      PA: if (k <= 9 && m_na < MAX_DIGITS) begin m_a = m_a * 10 + k; m_na++; end
          else if (k >= 10 && k <= 12 && m_na > 0) begin
            m_op = k - 10; m_b = 0; m_nb = 0; m_phase = PB;
          end
      PB: if (k <= 9 && m_nb < MAX_DIGITS) begin m_b = m_b * 10 + k; m_nb++; end
          else if (k >= 10 && k <= 12 && m_nb == 0) m_op = k - 10;
          else if (k == 13 && m_nb > 0) m_phase = PX;
      PS, PE: if (k <= 9) begin m_a = k; m_na = 1; m_b = 0; m_nb = 0; m_phase = PA; end
      default: ;
    endcase
  endtask

  task automatic check_view(input string tag);
    int ed, es;
    case (m_phase)
      PA:      begin ed = m_a;   es = 0; end
      PB, PX:  begin ed = m_b;   es = 1; end
      PS:      begin ed = m_res; es = 2; end
      default: begin ed = 0;     es = 3; end
    endcase
    check({tag, ":disp"}, 32'(disp_val), ed);
    check({tag, ":sel"},  32'(disp_sel), es);
    check({tag, ":err"},  32'(err),  (m_phase == PE) ? 1 : 0);
    check({tag, ":busy"}, 32'(busy), (m_phase == PX) ? 1 : 0);
  endtask

  task automatic press(input int k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'(k);
    @(negedge clk);
    key_valid = 1'b0;
    model_key(k);
  endtask

  task automatic press_seq(input string tag, input int keys[$]);
    foreach (keys[i]) press(keys[i]);
    check_view(tag);
  endtask

  // Called at the negedge right after equals was accepted (DUT in EXEC).
  task automatic run_alu(input string tag, input int dly, input bit force_err,
                         input int clr_at, input bit tmo);
    int r, last;
    bit e;
    check({tag, ":start"}, 32'(alu_start), 1);
    check({tag, ":a"},  32'(alu_a),  m_a);
    check({tag, ":b"},  32'(alu_b),  m_b);
    check({tag, ":op"}, 32'(alu_op), m_op);
    exp_starts++;
    case (m_op)
      0:       r = m_a + m_b;
      1:       r = m_a - m_b;
      default: r = m_a * m_b;
    endcase
    e = force_err || (r < 0);
    last = tmo ? TO_CYC : dly;
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      key_valid = 1'b0;
      alu_done  = 1'b0;
      if (i == 1) check({tag, ":pulse"}, 32'(alu_start), 0);
      if (i == last) check({tag, ":busy_last"}, 32'(busy), 1);
      if (i == clr_at) begin key_valid = 1'b1; key_code = 4'hE; end
      if (!tmo && i == dly) begin alu_done = 1'b1; alu_result = RW'(r); alu_err = e; end
    end
    @(negedge clk);
    key_valid = 1'b0; alu_done = 1'b0; alu_err = 1'b0;
    if (clr_at >= 1 && clr_at <= last) model_reset();
    else if (tmo || e) m_phase = PE;
    else begin m_phase = PS; m_res = r; end
    check_view({tag, ":end"});
  endtask

  initial begin
    int k, sel;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst:start", 32'(alu_start), 0);
    check("rst:op",    32'(alu_op), 0);
    check("rst:a",     32'(alu_a), 0);
    check("rst:b",     32'(alu_b), 0);
    check_view("rst");
    rst_n = 1'b1;

    // 1) 12 + 3 = 15
    press_seq("t1_keys", '{1, 2, 10, 3, 13});
    run_alu("t1", 5, 1'b0, 0, 1'b0);
    check("t1:res", 32'(disp_val), 15);

    // 2) fifth digit ignored
    press(14);
    press_seq("t2", '{9, 8, 7, 6, 5});
    check("t2:a", 32'(alu_a), 9876);

    // 3) operator/equals without A ignored; operator replaced while B empty
    press(14);
    press_seq("t3_ign", '{10, 13});
    press_seq("t3", '{4, 10, 11, 2});
    check("t3:op", 32'(alu_op), 1);
    press(13);
    run_alu("t3x", 3, 1'b0, 0, 1'b0);

    // done outside WAIT is ignored
    press(14);
    press(7);
    @(negedge clk); alu_done = 1'b1; alu_result = RW'(1234);
    @(negedge clk); alu_done = 1'b0;
    check_view("stray_done");

    // 4) clear during WAIT, then done
    press(14);
    press_seq("t4_keys", '{5, 12, 6, 13});
    run_alu("t4", 10, 1'b0, 3, 1'b0);
    // clear coincident with done
    press_seq("t4b_keys", '{2, 10, 2, 13});
    run_alu("t4b", 6, 1'b0, 6, 1'b0);

    // 5) timeout, then a digit recovers
    press_seq("t5_keys", '{7, 10, 1, 13});
    run_alu("t5", 0, 1'b0, 0, 1'b1);
    press(5);
    check_view("t5_rec");
    check("t5:a", 32'(alu_a), 5);

    // 6) ALU error, then async reset mid-WAIT
    press(14);
    press_seq("t6_keys", '{8, 12, 3, 13});
    run_alu("t6", 4, 1'b1, 0, 1'b0);
    press(14);
    press_seq("t6r_keys", '{2, 12, 2, 13});
    check("t6r:start", 32'(alu_start), 1);
    exp_starts++;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6r:start0", 32'(alu_start), 0);
    check("t6r:a0",     32'(alu_a), 0);
    check("t6r:b0",     32'(alu_b), 0);
    check("t6r:op0",    32'(alu_op), 0);
    model_reset();
    check_view("t6r");
    @(negedge clk);
    rst_n = 1'b1;

    // random key streams
    press(14);
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 55)      k = $urandom_range(0, 9);
      else if (sel < 70) k = 10 + $urandom_range(0, 2);
      else if (sel < 84) k = 13;
      else if (sel < 87) k = 14;
      else               k = 15;
      press(k);
      check_view("rnd");
      if (m_phase == PX) begin
        bit tmo;
        int dly, clr_at;
        tmo = ($urandom_range(0, 99) < 4);
        dly = $urandom_range(1, 20);
        clr_at = ($urandom_range(0, 99) < 20) ? $urandom_range(1, tmo ? TO_CYC : dly) : 0;
        run_alu("rnd_alu", dly, $urandom_range(0, 99) < 10, clr_at, tmo);
      end
    end

    check("start_count", n_starts, exp_starts);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
